// File: rtl/instrumented_adder_host.sv
// Host sequencer for the instrumented ripple adder: load operands, gate the ring oscillator
// for a programmed window, capture count/sum. Optional sum checker under RESULT_CHECK_EN.
module instrumented_adder_host #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned DRAIN_CYCLES  = 2,
  parameter int unsigned WIN_W         = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [WIN_W-1:0] cmd_window,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_count,
  output logic [31:0]      rsp_sum,
  output logic             rsp_err,
  output logic [31:0]      adder_a,
  output logic [31:0]      adder_b,
  output logic             adder_ring_en,
  output logic             adder_cnt_clr,
  input  logic [31:0]      adder_count,
  input  logic [31:0]      adder_sum
);

  // SETTLE_CYCLES and DRAIN_CYCLES are expected to be at least 1.
  localparam int unsigned DLY_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_DRAIN, S_CAPTURE, S_RESP
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [WIN_W-1:0]   r_win, w_win_nxt;
  logic [DLY_W-1:0]   r_dly, w_dly_nxt;
  logic               r_cmd_ready, w_cmd_ready_nxt;
  logic               r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0]        r_rsp_count, w_rsp_count_nxt;
  logic [31:0]        r_rsp_sum, w_rsp_sum_nxt;
  logic [31:0]        r_adder_a, w_adder_a_nxt;
  logic [31:0]        r_adder_b, w_adder_b_nxt;
  logic               r_ring_en, w_ring_en_nxt;
  logic               r_cnt_clr, w_cnt_clr_nxt;
`ifdef RESULT_CHECK_EN
  logic               r_rsp_err, w_rsp_err_nxt;
  logic [31:0]        w_exp_sum;

  assign w_exp_sum = r_adder_a + r_adder_b;
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state_nxt     = r_state;
    w_win_nxt       = r_win;
    w_dly_nxt       = r_dly;
    w_cmd_ready_nxt = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_count_nxt = r_rsp_count;
    w_rsp_sum_nxt   = r_rsp_sum;
    w_adder_a_nxt   = r_adder_a;
    w_adder_b_nxt   = r_adder_b;
    w_ring_en_nxt   = 1'b0;
    w_cnt_clr_nxt   = 1'b0;
`ifdef RESULT_CHECK_EN
    w_rsp_err_nxt   = r_rsp_err;
`endif
    case (r_state)
      S_IDLE: begin
        w_cmd_ready_nxt = 1'b1;
        if (cmd_valid && r_cmd_ready) begin
          w_state_nxt     = S_LOAD;
          w_cmd_ready_nxt = 1'b0;
          w_adder_a_nxt   = cmd_a;
          w_adder_b_nxt   = cmd_b;
          w_win_nxt       = (cmd_window == '0) ? WIN_W'(1) : cmd_window;
          w_cnt_clr_nxt   = 1'b1;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_SETTLE;
        w_dly_nxt   = DLY_W'(SETTLE_CYCLES - 1);
      end
      S_SETTLE: begin
        if (r_dly == '0) begin
          w_state_nxt   = S_RUN;
          w_ring_en_nxt = 1'b1;
        end else begin
          w_dly_nxt = r_dly - DLY_W'(1);
        end
      end
      // r_win holds the ring-enabled cycles remaining, including the current one.
      S_RUN: begin
        if (r_win == WIN_W'(1)) begin
          w_state_nxt = S_DRAIN;
          w_dly_nxt   = DLY_W'(DRAIN_CYCLES - 1);
        end else begin
          w_win_nxt     = r_win - WIN_W'(1);
          w_ring_en_nxt = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_dly == '0) begin
          w_state_nxt = S_CAPTURE;
        end else begin
          w_dly_nxt = r_dly - DLY_W'(1);
        end
      end
      S_CAPTURE: begin
        w_state_nxt     = S_RESP;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_count_nxt = adder_count;
        w_rsp_sum_nxt   = adder_sum;
`ifdef RESULT_CHECK_EN
        w_rsp_err_nxt   = (adder_sum != w_exp_sum);
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = S_IDLE;
          w_cmd_ready_nxt = 1'b1;
`ifdef RESULT_CHECK_EN
          w_rsp_err_nxt   = 1'b0;
`endif
        end else begin
          w_rsp_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_cmd_ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_win       <= '0;
      r_dly       <= '0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_count <= '0;
      r_rsp_sum   <= '0;
      r_adder_a   <= '0;
      r_adder_b   <= '0;
      r_ring_en   <= 1'b0;
      r_cnt_clr   <= 1'b0;
`ifdef RESULT_CHECK_EN
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_win       <= w_win_nxt;
      r_dly       <= w_dly_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_count <= w_rsp_count_nxt;
      r_rsp_sum   <= w_rsp_sum_nxt;
      r_adder_a   <= w_adder_a_nxt;
      r_adder_b   <= w_adder_b_nxt;
      r_ring_en   <= w_ring_en_nxt;
      r_cnt_clr   <= w_cnt_clr_nxt;
`ifdef RESULT_CHECK_EN
      r_rsp_err   <= w_rsp_err_nxt;
`endif
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_count     = r_rsp_count;
  assign rsp_sum       = r_rsp_sum;
  assign adder_a       = r_adder_a;
  assign adder_b       = r_adder_b;
  assign adder_ring_en = r_ring_en;
  assign adder_cnt_clr = r_cnt_clr;
`ifdef RESULT_CHECK_EN
  assign rsp_err       = r_rsp_err;
`else
  assign rsp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_instrumented_adder_host.sv
// Scoreboard bench for instrumented_adder_host with a behavioural adder/ring-counter model.
module tb_instrumented_adder_host;

  localparam int unsigned S  = 4;
  localparam int unsigned D  = 2;
  localparam int unsigned WW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [31:0]   cmd_a = '0;
  logic [31:0]   cmd_b = '0;
  logic [WW-1:0] cmd_window = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_count, rsp_sum;
  logic          rsp_err;
  logic [31:0]   adder_a, adder_b;
  logic          ring_en, cnt_clr;
  logic [31:0]   adder_count, adder_sum;
  logic [31:0]   m_cnt = '0;
  logic          sum_fault = 1'b0;

  always #5 clk = ~clk;

  instrumented_adder_host #(.SETTLE_CYCLES(S), .DRAIN_CYCLES(D), .WIN_W(WW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_window(cmd_window),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_count(rsp_count), .rsp_sum(rsp_sum), .rsp_err(rsp_err),
    .adder_a(adder_a), .adder_b(adder_b),
    .adder_ring_en(ring_en), .adder_cnt_clr(cnt_clr),
    .adder_count(adder_count), .adder_sum(adder_sum)
  );

  // Adder model: counter advances while the ring is enabled; sum can be corrupted on demand.
  always @(posedge clk) begin
    if (cnt_clr) m_cnt <= '0;
    else if (ring_en) m_cnt <= m_cnt + 32'd1;
  end
  assign adder_count = m_cnt;
  assign adder_sum   = sum_fault ? 32'h0000_0010 : adder_a + adder_b;

  typedef struct {
    logic [31:0] count;
    logic [31:0] sum;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_acc = 0;
  logic mon_en  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired, expected DUT event", name);
  endtask

  // Monitor: timing of clear/ring pulses, latency, hold-under-backpressure and response data.
  logic        prev_valid = 1'b0;
  logic        prev_hs    = 1'b0;
  logic        prev_ring  = 1'b0;
  logic [31:0] prev_count = '0;
  logic [31:0] prev_sum   = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (cnt_clr) chk("cnt_clr_cycle", 32'(cyc - last_acc), 32'd1);
      if (ring_en && !prev_ring) chk("ring_start", 32'(cyc - last_acc), 32'(2 + S));
      if (rsp_valid && !prev_valid) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rsp_valid with count 0x%0h, expected no response", rsp_count);
        end else begin
          chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
        end
      end
      if (rsp_valid && prev_valid && !prev_hs) begin
        chk("hold_count", rsp_count, prev_count);
        chk("hold_sum", rsp_sum, prev_sum);
      end
      prev_hs = rsp_valid && rsp_ready;
      if (rsp_valid && rsp_ready && q.size() != 0) begin
        m_e = q.pop_front();
        chk("rsp_count", rsp_count, m_e.count);
        chk("rsp_sum", rsp_sum, m_e.sum);
        chk("rsp_err", 32'(rsp_err), 32'(m_e.err));
      end
      prev_valid = rsp_valid;
      prev_ring  = ring_en;
      prev_count = rsp_count;
      prev_sum   = rsp_sum;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [WW-1:0] w, input logic fault);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      timeout_fail("cmd_ready_wait");
      return;
    end
    sum_fault  = fault;
    cmd_a      = a;
    cmd_b      = b;
    cmd_window = w;
    cmd_valid  = 1'b1;
    e.count = (w == '0) ? 32'd1 : 32'(w);
    e.sum   = fault ? 32'h0000_0010 : a + b;
`ifdef RESULT_CHECK_EN
    e.err   = fault;
`else
    e.err   = 1'b0;
`endif
    e.acc   = cyc;
    e.lat   = 3 + int'(S) + int'(e.count) + int'(D);
    q.push_back(e);
    last_acc = cyc;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((q.size() != 0 || !cmd_ready) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || !cmd_ready) timeout_fail("wait_idle");
  endtask

  task automatic wait_rsp(input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) timeout_fail("wait_rsp");
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_ring_en", 32'(ring_en), 32'd0);
    chk("rst_cnt_clr", 32'(cnt_clr), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_count", rsp_count, 32'd0);
    chk("rst_rsp_sum", rsp_sum, 32'd0);
    chk("rst_adder_a", adder_a, 32'd0);
    chk("rst_adder_b", adder_b, 32'd0);
    mon_en = 1'b1;

    // Basic measurement, then one-cycle response and immediate cmd_ready.
    send(32'd5, 32'd7, 16'd10, 1'b0);
    wait_rsp(100);
    @(negedge clk);
    chk("rsp_valid_one_cycle", 32'(rsp_valid), 32'd0);
    chk("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
    chk("adder_a_held", adder_a, 32'd5);
    chk("adder_b_held", adder_b, 32'd7);
    wait_idle(100);

    // Window zero behaves as one.
    send(32'd1, 32'd2, 16'd0, 1'b0);
    wait_idle(100);

    // Operand wrap.
    send(32'hFFFF_FFFF, 32'd1, 16'd3, 1'b0);
    wait_idle(100);

    // Corrupted sum, then a clean command.
    send(32'd3, 32'd4, 16'd2, 1'b1);
    wait_idle(100);
    send(32'd100, 32'd200, 16'd3, 1'b0);
    wait_idle(100);

    // Response backpressure with busy command pulses.
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    send(32'd9, 32'd10, 16'd5, 1'b0);
    wait_rsp(100);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      cmd_a     = 32'(i);
      cmd_b     = 32'd77;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_idle(100);

    // Reset while the ring is running.
    send(32'd11, 32'd22, 16'd40, 1'b0);
    n = 0;
    @(negedge clk);
    while (!ring_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ring_en) timeout_fail("wait_ring_en");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    @(negedge clk);
    chk("abort_ring_en", 32'(ring_en), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("abort_adder_a", adder_a, 32'd0);
    repeat (80) @(negedge clk);

    // Full-scale window.
    send(32'd1, 32'd1, 16'hFFFF, 1'b0);
    wait_idle(70000);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
